// File: rtl/sel_threshold_cmp_pipe_pkg.sv
// Shared definitions for the s1423-derived compare datapaths.
// This file holds the relation-select encoding and the default qualifier pattern.
package s1423_pkg;

    typedef enum logic [1:0] {
        CMP_LT = 2'b00,
        CMP_LE = 2'b01,
        CMP_GT = 2'b10,
        CMP_GE = 2'b11
    } cmp_mode_t;

    localparam logic [4:0] CTRL_MATCH_DEFAULT = 5'b00110;

endpackage

// File: rtl/sel_threshold_cmp_pipe_if.sv
// Sample, result and threshold bundle for sel_threshold_cmp_pipe.
// The master side is the producer/consumer environment; the slave side is the pipeline.
interface sel_threshold_cmp_pipe_if #(
    parameter int WIDTH  = 5,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic              sel;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CTRL_W-1:0] ctrl;
    logic              gate;
    logic [1:0]        mode;
    logic              thr_load;
    logic [WIDTH-1:0]  thr_in;
    logic [WIDTH-1:0]  thr_q;
    logic              out_valid;
    logic              out_ready;
    logic              cmp_hit;
    logic [CNT_W-1:0]  hit_count;
    logic              alarm;

    modport master (
        output in_valid, sel, op_a, op_b, ctrl, gate, mode, thr_load, thr_in, out_ready,
        input  in_ready, thr_q, out_valid, cmp_hit, hit_count, alarm
    );

    modport slave (
        input  in_valid, sel, op_a, op_b, ctrl, gate, mode, thr_load, thr_in, out_ready,
        output in_ready, thr_q, out_valid, cmp_hit, hit_count, alarm
    );

endinterface

// File: rtl/sel_threshold_cmp_pipe_mag_cmp_rel.sv
// Combinational unsigned magnitude compare of a against b with a selectable relation.
// Kept standalone so later pipeline variants can reuse it unchanged.
module mag_cmp_rel
    import s1423_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  cmp_mode_t        mode,
    output logic             rel
);

    always_comb begin
        rel = 1'b0;
        case (mode)
            CMP_LT:  rel = (a <  b);
            CMP_LE:  rel = (a <= b);
            CMP_GT:  rel = (a >  b);
            CMP_GE:  rel = (a >= b);
            default: rel = 1'b0;
        endcase
    end

endmodule

// File: rtl/sel_threshold_cmp_pipe.sv
// Two-stage valid/ready pipeline: S1 captures the muxed operand, S2 compares it against
// the threshold register and tracks a saturating streak of qualified hits.
module sel_threshold_cmp_pipe
    import s1423_pkg::*;
#(
    parameter int                WIDTH      = 5,
    parameter int                CTRL_W     = 5,
    parameter logic [CTRL_W-1:0] CTRL_MATCH = CTRL_MATCH_DEFAULT,
    parameter int                HOLD_MAX   = 3,
    localparam int               CNT_W      = $clog2(HOLD_MAX + 1)
) (
    input logic                   CK,
    input logic                   RST,
    sel_threshold_cmp_pipe_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_opnd;
    cmp_mode_t        s1_mode;
    logic             s1_qual;
    logic             s2_valid;
    logic             hit_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] thr_reg;

    logic             s2_free;
    logic             s1_adv;
    logic             in_ready_int;
    logic             accept;
    logic             raw;
    logic             next_hit;
    logic [CNT_W-1:0] cnt_next;

    // S2 can take a new result when empty or when its current result leaves this cycle.
    assign s2_free      = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_free;
    assign in_ready_int = !s1_valid || s1_adv;
    assign accept       = bus.in_valid && in_ready_int;

    mag_cmp_rel #(.WIDTH(WIDTH)) u_cmp (
        .a    (s1_opnd),
        .b    (thr_reg),
        .mode (s1_mode),
        .rel  (raw)
    );

    assign next_hit = raw && s1_qual;

    always_comb begin
        cnt_next = '0;
        if (next_hit) begin
            cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            s1_valid <= 1'b0;
        end else if (in_ready_int) begin
            s1_valid <= bus.in_valid;
        end
    end

    always_ff @(posedge CK) begin
        if (accept) begin
            s1_opnd <= bus.sel ? bus.op_b : bus.op_a;
            s1_mode <= cmp_mode_t'(bus.mode);
            s1_qual <= (bus.ctrl == CTRL_MATCH) && bus.gate;
        end
    end

    // Result and streak only move on an S1 -> S2 transfer, so stalled outputs stay put.
    always_ff @(posedge CK) begin
        if (RST) begin
            s2_valid <= 1'b0;
            hit_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                hit_q <= next_hit;
                cnt_q <= cnt_next;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            thr_reg <= '1;
        end else if (bus.thr_load) begin
            thr_reg <= bus.thr_in;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_valid;
    assign bus.cmp_hit   = hit_q;
    assign bus.hit_count = cnt_q;
    assign bus.alarm     = (cnt_q == CNT_MAX);
    assign bus.thr_q     = thr_reg;

endmodule

// File: tb/tb_sel_threshold_cmp_pipe.sv
// Self-checking bench for sel_threshold_cmp_pipe: directed scenarios plus random traffic,
// scored against a queue-based reference of the compare/streak rules.
module tb_sel_threshold_cmp_pipe;

    localparam int         HOLD_MAX = 3;
    localparam logic [4:0] MATCH    = 5'b00110;

    typedef struct {
        logic [4:0] opnd;
        logic [1:0] mode;
        logic       qual;
    } samp_t;

    typedef struct {
        logic hit;
        int   cnt;
    } res_t;

    logic CK;
    logic RST;

    sel_threshold_cmp_pipe_if #(.WIDTH(5), .CTRL_W(5), .CNT_W(2)) bus ();

    sel_threshold_cmp_pipe #(
        .WIDTH      (5),
        .CTRL_W     (5),
        .CTRL_MATCH (MATCH),
        .HOLD_MAX   (HOLD_MAX)
    ) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    int         n_asserts = 0;
    int         n_fail    = 0;
    samp_t      pend_q[$];
    res_t       res_q[$];
    logic [4:0] thr_model = 5'h1F;
    int         streak    = 0;
    int         obs_hit_q[$];
    int         obs_cnt_q[$];
    int         obs_alarm_q[$];
    int         exp_q[$];

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int obs[$], input int exp[$]);
        check_output({tag, "_len"}, obs.size(), exp.size());
        if (obs.size() == exp.size()) begin
            for (int i = 0; i < exp.size(); i++) begin
                check_output($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
            end
        end
    endtask

    function automatic logic rel(input logic [4:0] op, input logic [4:0] thr, input logic [1:0] m);
        case (m)
            2'd0:    return op <  thr;
            2'd1:    return op <= thr;
            2'd2:    return op >  thr;
            default: return op >= thr;
        endcase
    endfunction

    // One clock: check outputs against the reference, then advance the reference across the edge.
    task automatic tick();
        logic  exp_ir, exp_ov, fire, adv;
        samp_t s;
        res_t  r;
        #1;
        exp_ir = (pend_q.size() == 0) || (res_q.size() == 0) || bus.out_ready;
        exp_ov = (res_q.size() != 0);
        check_output("in_ready", bus.in_ready, exp_ir);
        check_output("out_valid", bus.out_valid, exp_ov);
        check_output("thr_q", bus.thr_q, thr_model);
        if (exp_ov) begin
            check_output("cmp_hit", bus.cmp_hit, res_q[0].hit);
            check_output("hit_count", bus.hit_count, res_q[0].cnt);
            check_output("alarm", bus.alarm, res_q[0].cnt == HOLD_MAX);
        end
        fire = exp_ov && bus.out_ready;
        if (fire) begin
            obs_hit_q.push_back(int'(bus.cmp_hit));
            obs_cnt_q.push_back(int'(bus.hit_count));
            obs_alarm_q.push_back(int'(bus.alarm));
        end
        if (RST) begin
            pend_q.delete();
            res_q.delete();
            thr_model = 5'h1F;
            streak    = 0;
        end else begin
            adv = (pend_q.size() != 0) && ((res_q.size() == 0) || fire);
            if (fire) void'(res_q.pop_front());
            if (adv) begin
                s      = pend_q.pop_front();
                r.hit  = rel(s.opnd, thr_model, s.mode) && s.qual;
                streak = r.hit ? ((streak == HOLD_MAX) ? streak : streak + 1) : 0;
                r.cnt  = streak;
                res_q.push_back(r);
            end
            if (bus.in_valid && exp_ir) begin
                s.opnd = bus.sel ? bus.op_b : bus.op_a;
                s.mode = bus.mode;
                s.qual = (bus.ctrl == MATCH) && bus.gate;
                pend_q.push_back(s);
            end
            if (bus.thr_load) thr_model = bus.thr_in;
        end
        @(posedge CK);
        @(negedge CK);
    endtask

    task automatic apply_stimulus(input logic v, input logic s, input logic [4:0] a, input logic [4:0] b,
                                  input logic [4:0] c, input logic g, input logic [1:0] m);
        bus.in_valid = v;
        bus.sel      = s;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.ctrl     = c;
        bus.gate     = g;
        bus.mode     = m;
        tick();
    endtask

    task automatic load_thr(input logic [4:0] t);
        bus.in_valid = 1'b0;
        bus.thr_load = 1'b1;
        bus.thr_in   = t;
        tick();
        bus.thr_load = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic clear_obs();
        obs_hit_q.delete();
        obs_cnt_q.delete();
        obs_alarm_q.delete();
    endtask

    initial begin
        RST           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sel       = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.ctrl      = '0;
        bus.gate      = 1'b0;
        bus.mode      = 2'd0;
        bus.thr_load  = 1'b0;
        bus.thr_in    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge CK);
        @(negedge CK);
        RST = 1'b0;
        $display("[TB] reset checks");
        check_output("rst_in_ready", bus.in_ready, 1'b1);
        check_output("rst_out_valid", bus.out_valid, 1'b0);
        check_output("rst_thr_q", bus.thr_q, 5'h1F);
        check_output("rst_cmp_hit", bus.cmp_hit, 1'b0);
        check_output("rst_hit_count", bus.hit_count, 2'd0);
        check_output("rst_alarm", bus.alarm, 1'b0);

        $display("[TB] mux/relation sweep");
        load_thr(5'd10);
        clear_obs();
        for (int m = 0; m < 4; m++) apply_stimulus(1'b1, 1'b0, 5'd10, 5'd0, MATCH, 1'b1, 2'(m));
        apply_stimulus(1'b1, 1'b1, 5'd0, 5'd11, MATCH, 1'b1, 2'd2);
        apply_stimulus(1'b1, 1'b0, 5'd9, 5'd0, MATCH, 1'b1, 2'd0);
        drain();
        exp_q = '{0, 1, 0, 1, 1, 1};
        check_seq("sweep_hit", obs_hit_q, exp_q);

        $display("[TB] reset mid-stream");
        apply_stimulus(1'b1, 1'b0, 5'd3, 5'd0, MATCH, 1'b1, 2'd0);
        apply_stimulus(1'b1, 1'b0, 5'd4, 5'd0, MATCH, 1'b1, 2'd0);
        RST          = 1'b1;
        bus.thr_load = 1'b1;
        bus.thr_in   = 5'd3;
        apply_stimulus(1'b0, 1'b0, 5'd0, 5'd0, MATCH, 1'b1, 2'd0);
        RST          = 1'b0;
        bus.thr_load = 1'b0;
        repeat (3) tick();
        check_output("rst_mid_thr_q", bus.thr_q, 5'h1F);

        $display("[TB] qualification");
        load_thr(5'd0);
        clear_obs();
        apply_stimulus(1'b1, 1'b0, 5'd31, 5'd0, MATCH, 1'b1, 2'd3);
        apply_stimulus(1'b1, 1'b0, 5'd31, 5'd0, 5'b00111, 1'b1, 2'd3);
        apply_stimulus(1'b1, 1'b0, 5'd31, 5'd0, MATCH, 1'b0, 2'd3);
        drain();
        exp_q = '{1, 0, 0};
        check_seq("qual_hit", obs_hit_q, exp_q);
        check_seq("qual_cnt", obs_cnt_q, exp_q);

        $display("[TB] streak");
        load_thr(5'd10);
        clear_obs();
        repeat (5) apply_stimulus(1'b1, 1'b0, 5'd20, 5'd0, MATCH, 1'b1, 2'd2);
        apply_stimulus(1'b1, 1'b0, 5'd5, 5'd0, MATCH, 1'b1, 2'd2);
        drain();
        exp_q = '{1, 2, 3, 3, 3, 0};
        check_seq("streak_cnt", obs_cnt_q, exp_q);
        exp_q = '{0, 0, 1, 1, 1, 0};
        check_seq("streak_alarm", obs_alarm_q, exp_q);

        $display("[TB] backpressure");
        clear_obs();
        bus.out_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 5'd12, 5'd0, MATCH, 1'b1, 2'd2);
        apply_stimulus(1'b1, 1'b0, 5'd3, 5'd0, MATCH, 1'b1, 2'd2);
        apply_stimulus(1'b1, 1'b0, 5'd14, 5'd0, MATCH, 1'b1, 2'd2);
        check_output("bp_in_ready_low", bus.in_ready, 1'b0);
        apply_stimulus(1'b1, 1'b0, 5'd15, 5'd0, MATCH, 1'b1, 2'd2);
        drain();
        exp_q = '{1, 0};
        check_seq("bp_hit", obs_hit_q, exp_q);

        $display("[TB] threshold timing");
        clear_obs();
        apply_stimulus(1'b1, 1'b0, 5'd15, 5'd0, MATCH, 1'b1, 2'd2);
        bus.thr_load = 1'b1;
        bus.thr_in   = 5'd20;
        apply_stimulus(1'b1, 1'b0, 5'd15, 5'd0, MATCH, 1'b1, 2'd2);
        bus.thr_load = 1'b0;
        drain();
        exp_q = '{1, 0};
        check_seq("thr_hit", obs_hit_q, exp_q);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.thr_load  = ($urandom_range(0, 15) == 0);
            bus.thr_in    = 5'($urandom);
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                           ($urandom_range(0, 3) != 0) ? MATCH : 5'($urandom),
                           ($urandom_range(0, 7) != 0), 2'($urandom));
        end
        bus.thr_load = 1'b0;
        drain();
        check_output("final_empty", pend_q.size() + res_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
